// File: rtl/dcr_id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection; drives the x/y/funct inputs of the EX-stage ALU.
module dcr_id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_use_imm,
    input  logic               id_use_shamt,
    input  logic [4:0]         id_shamt,
    input  logic [3:0]         id_funct,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               flush,
    input  logic               exm_reg_write,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic [DATA_W-1:0]  exm_result,
    input  logic               mwb_reg_write,
    input  logic [RADDR_W-1:0] mwb_rd,
    input  logic [DATA_W-1:0]  mwb_result,
    output logic               stall_id,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_x,
    output logic [DATA_W-1:0]  ex_y,
    output logic [3:0]         ex_funct,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read
);

    logic               valid_q, valid_d;
    logic [RADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q;
    logic               use_imm_q, use_shamt_q;
    logic [4:0]         shamt_q;
    logic [3:0]         funct_q;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q, mem_read_d;

    logic rs_hit, rt_hit;

    // A shift takes x from shamt, so its rs field is not a real source.
    assign rs_hit   = (rd_q == id_rs) && !id_use_shamt;
    assign rt_hit   = (rd_q == id_rt) && !id_use_imm;
    assign stall_id = id_valid && valid_q && mem_read_q && (rd_q != '0) && (rs_hit || rt_hit);

    always_comb begin
        valid_d     = id_valid;
        reg_write_d = id_reg_write && id_valid;
        mem_read_d  = id_mem_read && id_valid;
        if (flush || stall_id) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            use_shamt_q <= 1'b0;
            shamt_q     <= '0;
            funct_q     <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            // Payload is don't-care in a bubble, so it is captured unconditionally.
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rd_q        <= id_rd;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
            use_shamt_q <= id_use_shamt;
            shamt_q     <= id_shamt;
            funct_q     <= id_funct;
        end
    end

    // Operand 0 is A (rs), operand 1 is B (rt).
    logic [RADDR_W-1:0] src_idx  [2];
    logic [DATA_W-1:0]  src_data [2];
    logic [DATA_W-1:0]  fwd_data [2];

    assign src_idx[0]  = rs_q;
    assign src_idx[1]  = rt_q;
    assign src_data[0] = rs_data_q;
    assign src_data[1] = rt_data_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            if (FWD_EN) begin : g_on
                always_comb begin
                    fwd_data[gi] = src_data[gi];
                    if (exm_reg_write && (exm_rd != '0) && (exm_rd == src_idx[gi]))
                        fwd_data[gi] = exm_result;
                    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src_idx[gi]))
                        fwd_data[gi] = mwb_result;
                end
            end else begin : g_off
                assign fwd_data[gi] = src_data[gi];
            end
        end
    endgenerate

    assign ex_x         = use_shamt_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_data[0];
    assign ex_y         = use_imm_q ? imm_q : fwd_data[1];
    assign ex_valid     = valid_q;
    assign ex_funct     = funct_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q && valid_q;
    assign ex_mem_read  = mem_read_q && valid_q;

endmodule
